conv_mode_ctrl: RTL and testbench

- Frame-synchronous sequencer for the conv_kernel filter datapath.
- Debounces a push-button and steps the filter mode through NUM_MODES values.
- Commits a new mode only at a vertical-sync boundary, then holds conv_kernel disabled (en_o=0) while its line buffers refill.
- Drives mode/status to one HEX digit. Sits between the board KEY/SW inputs and conv_kernel.en_i / mode select; clocked by the VGA pixel clock.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/key_debounce.sv | 58 +++++
 rtl/conv_mode_ctrl.sv | 165 ++++++++++++++++
 tb/tb_conv_mode_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared types and constants for the conv_kernel mode controller
// Rev 1.0  : initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] c_MODE_PASS  = 2'd0;
  localparam logic [1:0] c_MODE_BLUR  = 2'd1;
  localparam logic [1:0] c_MODE_SHARP = 2'd2;
  localparam logic [1:0] c_MODE_EDGE  = 2'd3;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_SEG_0 = 7'b1000000;
  localparam logic [6:0] c_SEG_1 = 7'b1111001;
  localparam logic [6:0] c_SEG_2 = 7'b0100100;
  localparam logic [6:0] c_SEG_3 = 7'b0110000;

  function automatic logic [6:0] seg_decode(input logic [1:0] mode);
    logic [6:0] seg;
    case (mode)
      c_MODE_PASS:  seg = c_SEG_0;
      c_MODE_BLUR:  seg = c_SEG_1;
      c_MODE_SHARP: seg = c_SEG_2;
      default:      seg = c_SEG_3;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-flop synchronizer, stability counter and press pulse
// Rev 1.0      : initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stable;
  logic             w_accept;

  // Any change of the synced level restarts the stability window
  assign w_stable = (r_sync2 == r_prev);
  assign w_accept = w_stable && (r_cnt == c_CNT_MAX) && (r_sync2 != r_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_press <= w_accept & ~r_sync2;
      if (!w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_level <= r_sync2;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/conv_mode_ctrl.sv
`default_nettype none
// ============================================================================
// conv_mode_ctrl : frame-synchronous filter-mode sequencer for conv_kernel
// Rev 1.0        : initial release
// ============================================================================
module conv_mode_ctrl
  import conv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2,
  parameter int WARMUP_LINES    = 2
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              key_ni,
  input  logic              sw_bypass_i,
  input  logic              vs_ni,
  input  logic              hs_ni,
  output logic [MODE_W-1:0] mode_o,
  output logic              en_o,
  output logic              pending_o,
  output logic [7:0]        frame_cnt_o,
  output logic [6:0]        hex_no
);

  localparam int LINE_W = $clog2(WARMUP_LINES + 1);
  localparam logic [LINE_W-1:0] c_LINES    = LINE_W'(WARMUP_LINES);
  localparam logic [MODE_W-1:0] c_MODE_TOP = MODE_W'(NUM_MODES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_byp1;
  logic                r_byp2;
  logic                r_vs_prev;
  logic                r_hs_prev;
  logic                w_vs_fall;
  logic                w_hs_fall;
  logic                w_press;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   w_line_inc;
  logic [MODE_W-1:0]   r_pend_mode;
  logic [MODE_W-1:0]   w_pend_next;
  logic                r_pending;
  logic [MODE_W-1:0]   r_mode;
  logic                r_en;
  logic [7:0]          r_frame;
  logic [6:0]          r_hex;
  logic                w_en_next;
  logic                w_commit;
  logic                w_line_clr;
  logic                w_line_step;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (RESET_N),
    .i_key_n (key_ni),
    .o_press (w_press)
  );

  assign w_vs_fall   = r_vs_prev & ~vs_ni;
  assign w_hs_fall   = r_hs_prev & ~hs_ni;
  assign w_line_inc  = r_line + LINE_W'(1);
  assign w_pend_next = (r_pend_mode == c_MODE_TOP) ? '0 : r_pend_mode + MODE_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_en_next    = 1'b0;
    w_commit     = 1'b0;
    w_line_clr   = 1'b0;
    w_line_step  = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_vs_fall) begin
          w_state_next = ST_FLUSH;
          w_line_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        w_en_next = ~r_byp2;
        if (r_pending) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        w_en_next = ~r_byp2;
        if (w_vs_fall) begin
          w_commit     = 1'b1;
          w_line_clr   = 1'b1;
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave on the hsync edge that completes the warm-up count
        if (w_hs_fall) begin
          if (w_line_inc == c_LINES) begin
            w_state_next = ST_RUN;
          end else begin
            w_line_step = 1'b1;
          end
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_byp1      <= 1'b0;
      r_byp2      <= 1'b0;
      r_vs_prev   <= 1'b1;
      r_hs_prev   <= 1'b1;
      r_line      <= '0;
      r_pend_mode <= '0;
      r_pending   <= 1'b0;
      r_mode      <= '0;
      r_en        <= 1'b0;
      r_frame     <= '0;
      r_hex       <= c_SEG_0;
    end else begin
      r_byp1    <= sw_bypass_i;
      r_byp2    <= r_byp1;
      r_vs_prev <= vs_ni;
      r_hs_prev <= hs_ni;
      r_en      <= w_en_next;
      r_hex     <= seg_decode(2'(r_mode));
      if (w_vs_fall) begin
        r_frame <= r_frame + 8'd1;
      end
      if (w_line_clr) begin
        r_line <= '0;
      end else if (w_line_step) begin
        r_line <= w_line_inc;
      end
      // A press coinciding with a commit keeps the request alive for next frame
      if (w_press) begin
        r_pend_mode <= w_pend_next;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_commit) begin
        r_mode <= r_pend_mode;
      end
    end
  end

  assign mode_o      = r_mode;
  assign en_o        = r_en;
  assign pending_o   = r_pending;
  assign frame_cnt_o = r_frame;
  assign hex_no      = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_conv_mode_ctrl.sv
`default_nettype none
// ============================================================================
// tb_conv_mode_ctrl : directed self-checking bench for conv_mode_ctrl
// Rev 1.0           : initial release
// ============================================================================
module tb_conv_mode_ctrl;

  localparam logic [6:0] c_HEX0 = 7'b1000000;
  localparam logic [6:0] c_HEX1 = 7'b1111001;
  localparam logic [6:0] c_HEX2 = 7'b0100100;
  localparam logic [6:0] c_HEX3 = 7'b0110000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       byp = 1'b0;
  logic       vs_n = 1'b1;
  logic       hs_n = 1'b1;
  logic [1:0] mode_o;
  logic       en_o;
  logic       pending_o;
  logic [7:0] frame_cnt_o;
  logic [6:0] hex_no;

  int n_checks = 0;
  int n_errors = 0;

  conv_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .NUM_MODES       (4),
    .MODE_W          (2),
    .WARMUP_LINES    (2)
  ) u_dut (
    .clk         (clk),
    .RESET_N     (rst_n),
    .key_ni      (key_n),
    .sw_bypass_i (byp),
    .vs_ni       (vs_n),
    .hs_ni       (hs_n),
    .mode_o      (mode_o),
    .en_o        (en_o),
    .pending_o   (pending_o),
    .frame_cnt_o (frame_cnt_o),
    .hex_no      (hex_no)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_outs(input string tag, input int m, input int e, input int p);
    check({tag, "_mode"}, int'(mode_o), m);
    check({tag, "_en"}, int'(en_o), e);
    check({tag, "_pending"}, int'(pending_o), p);
  endtask

  task automatic vs_pulse();
    vs_n = 1'b0;
    tick(1);
    vs_n = 1'b1;
    tick(1);
  endtask

  task automatic hs_pulse();
    hs_n = 1'b0;
    tick(1);
    hs_n = 1'b1;
    tick(2);
  endtask

  // Key low long enough for one accepted press, then released and settled
  task automatic press_key();
    key_n = 1'b0;
    tick(6);
    key_n = 1'b1;
    tick(10);
  endtask

  // Two warm-up lines: enable stays low until the cycle after the second edge
  task automatic warmup(input string tag);
    check({tag, "_en_flush"}, int'(en_o), 0);
    hs_pulse();
    check({tag, "_en_line1"}, int'(en_o), 0);
    hs_n = 1'b0;
    tick(1);
    check({tag, "_en_line2"}, int'(en_o), 0);
    hs_n = 1'b1;
    tick(1);
    check({tag, "_en_run"}, int'(en_o), 1);
    tick(2);
  endtask

  initial begin
    // Test 1: reset state, INIT -> FLUSH -> RUN
    tick(3);
    expect_outs("rst", 0, 0, 0);
    check("rst_frame", int'(frame_cnt_o), 0);
    check("rst_hex", int'(hex_no), int'(c_HEX0));
    rst_n = 1'b1;
    tick(3);
    check("init_en", int'(en_o), 0);
    vs_pulse();
    check("t1_frame", int'(frame_cnt_o), 1);
    warmup("t1");
    expect_outs("t1_run", 0, 1, 0);
    check("t1_hex", int'(hex_no), int'(c_HEX0));

    // Test 2: single press commits at the next vsync
    press_key();
    expect_outs("t2_armed", 0, 1, 1);
    vs_pulse();
    expect_outs("t2_commit", 1, 0, 0);
    check("t2_hex", int'(hex_no), int'(c_HEX1));
    check("t2_frame", int'(frame_cnt_o), 2);
    warmup("t2");

    // Test 3: short glitches produce no press
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(1);
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(12);
    check("t3_pending", int'(pending_o), 0);
    vs_pulse();
    tick(2);
    expect_outs("t3_after_vs", 1, 1, 0);
    check("t3_frame", int'(frame_cnt_o), 3);

    // Test 4: reset, then four presses wrap 3 -> 0 with one commit
    rst_n = 1'b0;
    tick(1);
    check("t4_rst_frame", int'(frame_cnt_o), 0);
    check("t4_rst_mode", int'(mode_o), 0);
    rst_n = 1'b1;
    tick(2);
    vs_pulse();
    warmup("t4_init");
    for (int i = 0; i < 4; i++) press_key();
    check("t4_pending", int'(pending_o), 1);
    vs_pulse();
    expect_outs("t4_commit", 0, 0, 0);
    check("t4_hex", int'(hex_no), int'(c_HEX0));
    check("t4_frame", int'(frame_cnt_o), 2);
    warmup("t4");

    // Test 5: press and vsync land on the same ARMED cycle
    press_key();
    check("t5_pending", int'(pending_o), 1);
    key_n = 1'b0;
    tick(6);
    key_n = 1'b1;
    tick(1);
    vs_n = 1'b0;
    tick(1);
    vs_n = 1'b1;
    tick(10);
    expect_outs("t5_commit1", 1, 0, 1);
    check("t5_frame", int'(frame_cnt_o), 3);
    warmup("t5");
    vs_pulse();
    expect_outs("t5_commit2", 2, 0, 0);
    check("t5_hex", int'(hex_no), int'(c_HEX2));
    warmup("t5b");

    // Test 6: bypass latency, then async reset in FLUSH
    byp = 1'b1;
    tick(2);
    check("t6_byp_early", int'(en_o), 1);
    tick(1);
    check("t6_byp_en", int'(en_o), 0);
    check("t6_byp_mode", int'(mode_o), 2);
    byp = 1'b0;
    tick(4);
    check("t6_unbyp_en", int'(en_o), 1);
    press_key();
    vs_pulse();
    tick(1);
    expect_outs("t6_commit", 3, 0, 0);
    check("t6_hex", int'(hex_no), int'(c_HEX3));
    check("t6_frame", int'(frame_cnt_o), 5);
    hs_pulse();
    rst_n = 1'b0;
    #1;
    expect_outs("t6_async_rst", 0, 0, 0);
    check("t6_async_frame", int'(frame_cnt_o), 0);
    check("t6_async_hex", int'(hex_no), int'(c_HEX0));
    tick(2);
    rst_n = 1'b1;
    tick(3);
    expect_outs("t6_init_hold", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
